spirxdata: RTL
==============

Name: spirxdata

Overview:
- Receives one SD-card data block over the shared SPI byte interface and stores it in a dual-port block buffer.
- Clocks out 0xFF filler bytes, hunts for the 0xFE start token, and packs the payload MSB-first into DW-bit words written to memory.
- Checks the trailing CRC16 and reports one completion status byte to the SD command controller.
- Receive-side counterpart of the block transmitter; shares the low-level SPI byte engine and the buffer address map.

Parameters:
- DW, 32, memory word width in bits; multiple of 8.
- AW, 8, buffer address width; MSB selects buffer, low AW-1 bits are word index.
- TOKEN_TIMEOUT, 16'd4095, filler bytes allowed before start token (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  begin block read; sampled only when !o_busy
- i_lgblksz  in  4  log2 block bytes; clamped to 3..9 at start
- i_fifo  in  1  destination buffer select, latched at start
- o_busy  out  1  transfer in progress
- i_ll_busy  in  1  low-level SPI engine busy
- o_ll_stb  out  1  request one byte exchange
- o_ll_byte  out  8  transmitted byte; constant 8'hff
- i_ll_stb  in  1  received byte valid
- i_ll_byte  in  8  received byte
- o_write  out  1  one-cycle memory write strobe
- o_addr  out  AW  write address {fifo, index}
- o_data  out  DW  write data
- o_rxvalid  out  1  one-cycle completion pulse
- o_response  out  8  completion status, valid with o_rxvalid and held after

Behaviour:
- Reset: o_busy, o_ll_stb, o_write, o_rxvalid = 0; o_response = 0; state IDLE. Reset mid-transfer aborts with no o_rxvalid.
- States: IDLE, TOKEN, DATA, CRC_HI, CRC_LO, DONE.
- IDLE: on i_start, o_busy<=1, latch i_fifo and clamped lgblksz, clear CRC, byte count, index; go to TOKEN. i_start while busy is ignored.
- Byte pacing: exactly one exchange outstanding. o_ll_stb rises one cycle after entering a receive state or after the previous i_ll_stb. It drops on the first cycle with o_ll_stb && !i_ll_busy. It stays low until the next i_ll_stb. No o_ll_stb in IDLE/DONE.
- TOKEN: byte 0xFF -> stay. Byte 0xFE -> DATA. Byte with [7:5]==3'b000 -> data error token: o_response <= byte, go DONE. Any other byte -> treat as filler, stay.
- DATA: each byte shifts into an assembly register MSB-first and updates CRC16 (poly 0x1021, init 0, MSB-first).
- DATA word write: after DW/8 bytes, o_write pulses the cycle after the last byte's i_ll_stb, with o_data = assembled word and o_addr = {fifo, index}. index increments after each write, no wrap.
- DATA exit: after 2^lgblksz bytes (count width 10), go CRC_HI.
- CRC_HI / CRC_LO: capture received CRC high then low byte. After the CRC_LO byte, o_response <= 8'h00 if received CRC equals computed CRC, else 8'h80. Go DONE.
- DONE: o_rxvalid=1 for one cycle, o_busy still 1. Next cycle: o_busy=0, IDLE.
- Latency: o_write at 1 cycle after byte; o_rxvalid at 1 cycle after final i_ll_stb.
- Stray i_ll_stb while no exchange is outstanding is ignored.

Optional Feature:
- Macro SPIRXDATA_TIMEOUT_EN.
- Defined: TOKEN counts received filler bytes. When the count reaches TOKEN_TIMEOUT without 0xFE or an error token, o_response <= 8'h40, go DONE. Counter clears at start.
- Undefined: TOKEN waits indefinitely and no counter logic exists.

Test Plan:
- lgblksz=3, fifo=0, bytes FF,FF,FE, 8x00, CRC 00,00 -> writes 0x00000000 at addr 0x00 and 0x01; o_response=0x00; o_busy low 1 cycle after o_rxvalid.
- lgblksz=3, fifo=1, FE, 01..08, bench-model CRC -> writes 0x01020304@0x80, 0x05060708@0x81; response 0x00.
- Same as the previous case with the CRC low byte flipped -> identical writes; response 0x80.
- FF, 0x05 error token -> no o_write; response 0x05; exactly 2 ll_stb requests.
- lgblksz=9 with i_ll_busy toggled randomly -> 128 writes at addrs 0..127, never two outstanding requests; i_reset asserted mid-block in a second run -> all outputs 0 next cycle, no o_rxvalid.
- With SPIRXDATA_TIMEOUT_EN, TOKEN_TIMEOUT=4, 4x FF -> response 0x40 after fourth byte.

Source files
------------

// File: rtl/spirxdata.sv
// spirxdata: receives one SD-card data block over the shared SPI byte engine.
// Sends 0xFF filler bytes and hunts for the 0xFE start token. The payload is
// packed MSB-first into DW-bit words and written to the dual-port block buffer
// at {fifo, index}. The trailing CRC16 is checked, and one status byte is
// reported on o_response together with a one-cycle o_rxvalid pulse.
// Optional build macro SPIRXDATA_TIMEOUT_EN: gives up after TOKEN_TIMEOUT
// filler bytes while waiting for the start token and reports status 0x40.
module spirxdata #(
   parameter int          DW            = 32,
   parameter int          AW            = 8,
   parameter logic [15:0] TOKEN_TIMEOUT = 16'd4095
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [3:0]    i_lgblksz,
   input  logic          i_fifo,
   output logic          o_busy,
   input  logic          i_ll_busy,
   output logic          o_ll_stb,
   output logic [7:0]    o_ll_byte,
   input  logic          i_ll_stb,
   input  logic [7:0]    i_ll_byte,
   output logic          o_write,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data,
   output logic          o_rxvalid,
   output logic [7:0]    o_response
);

   localparam int WB  = DW / 8;
   localparam int WCW = (WB > 1) ? $clog2(WB) : 1;

   typedef enum logic [2:0] {
      IDLE, TOKEN, DATA, CRC_HI, CRC_LO, DONE
   } state_t;

   state_t        state, state_next;
   logic          waiting;      // a byte exchange has been accepted and is awaiting i_ll_stb
   logic          kick;         // delayed first request after leaving IDLE
   logic          fifo_r;
   logic [3:0]    lg_r;
   logic [3:0]    lg_clamped;
   logic [9:0]    byte_cnt;
   logic [9:0]    blk_last;
   logic [WCW-1:0] wcnt;
   logic [AW-2:0] index;
   logic [DW-1:0] shift;
   logic [DW-1:0] word_next;
   logic [15:0]   crc;
   logic [15:0]   crc_next;
   logic [7:0]    crc_rx_hi;
   logic          byte_ok;
   logic          word_done;
   logic          next_is_rx;
   logic          tok_is_start;
   logic          tok_is_error;
   logic          tok_timeout;

   // CRC16-CCITT (poly 0x1021), one byte MSB-first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      // NOTE: blocking updates are correct here: r is a local temporary stepped bit by bit.
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign lg_clamped   = (i_lgblksz < 4'd3) ? 4'd3 : (i_lgblksz > 4'd9) ? 4'd9 : i_lgblksz;
   assign blk_last     = (10'd1 << lg_r) - 10'd1;
   assign byte_ok      = waiting && i_ll_stb;
   assign word_next    = (shift << 8) | DW'(i_ll_byte);
   assign word_done    = (wcnt == WCW'(WB - 1));
   assign crc_next     = crc16_byte(crc, i_ll_byte);
   assign tok_is_start = (i_ll_byte == 8'hfe);
   assign tok_is_error = (i_ll_byte[7:5] == 3'b000);
   assign next_is_rx   = (state_next != IDLE) && (state_next != DONE);

   assign o_busy    = (state != IDLE);
   assign o_rxvalid = (state == DONE);
   assign o_ll_byte = 8'hff;

`ifdef SPIRXDATA_TIMEOUT_EN
   logic [15:0] tcnt;

   // Count filler bytes seen while hunting for the start token.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         tcnt <= '0;
      else if (state == IDLE && i_start)
         tcnt <= '0;
      else if (state == TOKEN && byte_ok && !tok_is_start && !tok_is_error)
         tcnt <= tcnt + 16'd1;
   end

   assign tok_timeout = (tcnt + 16'd1 == TOKEN_TIMEOUT);
`else
   logic unused_timeout;
   // The timeout limit has no role without the token timeout feature.
   assign unused_timeout = ^TOKEN_TIMEOUT;
   assign tok_timeout    = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state decode: each receive state advances only on an accepted byte.
   always_comb begin
      // NOTE: default assigned first so every path drives state_next; no latch is inferred.
      state_next = state;
      case (state)
         IDLE:    if (i_start) state_next = TOKEN;
         TOKEN:   if (byte_ok) begin
                     if (tok_is_start)                     state_next = DATA;
                     else if (tok_is_error || tok_timeout) state_next = DONE;
                  end
         DATA:    if (byte_ok && byte_cnt == blk_last) state_next = CRC_HI;
         CRC_HI:  if (byte_ok) state_next = CRC_LO;
         CRC_LO:  if (byte_ok) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Byte pacing, word assembly, CRC and status datapath.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ll_stb   <= 1'b0;
         waiting    <= 1'b0;
         kick       <= 1'b0;
         o_write    <= 1'b0;
         o_addr     <= '0;
         o_data     <= '0;
         o_response <= '0;
         fifo_r     <= 1'b0;
         lg_r       <= 4'd3;
         byte_cnt   <= '0;
         wcnt       <= '0;
         index      <= '0;
         shift      <= '0;
         crc        <= '0;
         crc_rx_hi  <= '0;
      end else begin
         // NOTE: non-blocking throughout so every read in this block sees pre-edge values.
         o_write <= 1'b0;
         kick    <= 1'b0;
         if (kick)
            o_ll_stb <= 1'b1;
         if (o_ll_stb && !i_ll_busy) begin
            o_ll_stb <= 1'b0;
            waiting  <= 1'b1;
         end
         if (byte_ok) begin
            waiting <= 1'b0;
            if (next_is_rx) o_ll_stb <= 1'b1;
         end

         case (state)
            IDLE: if (i_start) begin
               fifo_r   <= i_fifo;
               lg_r     <= lg_clamped;
               crc      <= '0;
               byte_cnt <= '0;
               wcnt     <= '0;
               index    <= '0;
               kick     <= 1'b1;
            end
            TOKEN: if (byte_ok && !tok_is_start) begin
               if (tok_is_error)     o_response <= i_ll_byte;
               else if (tok_timeout) o_response <= 8'h40;
            end
            DATA: if (byte_ok) begin
               crc      <= crc_next;
               byte_cnt <= byte_cnt + 10'd1;
               shift    <= word_next;
               if (word_done) begin
                  wcnt    <= '0;
                  o_write <= 1'b1;
                  o_data  <= word_next;
                  o_addr  <= {fifo_r, index};
                  index   <= index + 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            CRC_HI: if (byte_ok) crc_rx_hi <= i_ll_byte;
            CRC_LO: if (byte_ok)
               o_response <= ({crc_rx_hi, i_ll_byte} == crc) ? 8'h00 : 8'h80;
            default: ;
         endcase
      end
   end

endmodule
